// File: rtl/bsg_cache_sbuf_deep.sv
// rtl/bsg_cache_sbuf_deep.sv - parametrised-depth store buffer with back-pressure and byte-merging load bypass
module bsg_cache_sbuf_deep #(
  parameter int addr_width_p = 39,
  parameter int data_width_p = 64,
  parameter int ways_p = 8,
  parameter int els_p = 4,
  localparam int lg_ways_lp = $clog2(ways_p),
  localparam int mask_width_lp = data_width_p / 8,
  localparam int byte_sel_lp = $clog2(mask_width_lp),
  localparam int entry_width_lp = addr_width_p + data_width_p + mask_width_lp + lg_ways_lp,
  localparam int count_width_lp = $clog2(els_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [entry_width_lp-1:0] sbuf_entry_i,
  input  logic                      v_i,
  output logic                      ready_o,
  output logic [entry_width_lp-1:0] sbuf_entry_o,
  output logic                      v_o,
  input  logic                      yumi_i,
  output logic                      empty_o,
  output logic                      full_o,
  output logic [count_width_lp-1:0] count_o,
  input  logic [addr_width_p-1:0]   bypass_addr_i,
  input  logic                      bypass_v_i,
  output logic [data_width_p-1:0]   bypass_data_o,
  output logic [mask_width_lp-1:0]  bypass_mask_o
);

  localparam int lg_els_lp = $clog2(els_p);
  localparam int tag_width_lp = addr_width_p - byte_sel_lp;
  localparam int data_lsb_lp = lg_ways_lp + mask_width_lp;

  logic [entry_width_lp-1:0] r_mem [els_p];
  logic [lg_els_lp-1:0]      r_rd_ptr;
  logic [lg_els_lp-1:0]      r_wr_ptr;
  logic [count_width_lp-1:0] r_count;
  logic [data_width_p-1:0]   r_bypass_data;
  logic [mask_width_lp-1:0]  r_bypass_mask;

  logic w_empty, w_full, w_enq, w_write, w_pop;
  logic [lg_els_lp-1:0] w_rd_ptr_inc, w_wr_ptr_inc;

  // candidates for the bypass merge in age order: [0] oldest stored, [els_p] incoming store
  logic [els_p:0][entry_width_lp-1:0] w_cand;
  logic [els_p:0]                     w_cand_v;
  logic [data_width_p-1:0]            w_bp_data;
  logic [mask_width_lp-1:0]           w_bp_mask;
  logic                               w_unused;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == count_width_lp'(els_p));
  assign w_enq   = v_i & ~w_full;
  // an enqueue into an empty buffer that is consumed the same cycle never touches storage
  assign w_write = w_enq & ~(w_empty & yumi_i);
  assign w_pop   = yumi_i & ~w_empty;

  assign w_rd_ptr_inc = (r_rd_ptr == lg_els_lp'(els_p - 1)) ? '0 : r_rd_ptr + lg_els_lp'(1);
  assign w_wr_ptr_inc = (r_wr_ptr == lg_els_lp'(els_p - 1)) ? '0 : r_wr_ptr + lg_els_lp'(1);

  assign ready_o       = ~w_full;
  assign empty_o       = w_empty;
  assign full_o        = w_full;
  assign count_o       = r_count;
  assign sbuf_entry_o  = w_empty ? sbuf_entry_i : r_mem[r_rd_ptr];
  assign v_o           = w_empty ? v_i : 1'b1;
  assign bypass_data_o = r_bypass_data;
  assign bypass_mask_o = r_bypass_mask;

  // entry storage is write-only on enqueue and deliberately left unreset
  always_ff @(posedge clk_i) begin
    if (w_write) r_mem[r_wr_ptr] <= sbuf_entry_i;
  end

  // circular pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) r_wr_ptr <= w_wr_ptr_inc;
      if (w_pop)   r_rd_ptr <= w_rd_ptr_inc;
      r_count <= r_count + count_width_lp'(w_write) - count_width_lp'(w_pop);
    end
  end

  for (genvar g = 0; g < els_p; g++) begin : g_age
    logic [lg_els_lp:0] w_sum;
    logic [lg_els_lp-1:0] w_idx;
    assign w_sum = {1'b0, r_rd_ptr} + (lg_els_lp + 1)'(g);
    assign w_idx = (w_sum >= (lg_els_lp + 1)'(els_p)) ? lg_els_lp'(w_sum - (lg_els_lp + 1)'(els_p))
                                                      : w_sum[lg_els_lp-1:0];
    assign w_cand[g]   = r_mem[w_idx];
    assign w_cand_v[g] = (count_width_lp'(g) < r_count);
  end
  assign w_cand[els_p]   = sbuf_entry_i;
  assign w_cand_v[els_p] = w_enq;

  // walk oldest to youngest so younger matching bytes overwrite older ones
  always_comb begin
    w_bp_data = '0;
    w_bp_mask = '0;
    for (int i = 0; i <= els_p; i++) begin
      if (w_cand_v[i] &&
          (w_cand[i][entry_width_lp-1 -: tag_width_lp] == bypass_addr_i[addr_width_p-1:byte_sel_lp])) begin
        for (int b = 0; b < mask_width_lp; b++) begin
          if (w_cand[i][lg_ways_lp + b]) begin
            w_bp_mask[b]       = 1'b1;
            w_bp_data[8*b +: 8] = w_cand[i][data_lsb_lp + 8*b +: 8];
          end
        end
      end
    end
  end

  assign w_unused = ^{bypass_addr_i[byte_sel_lp-1:0], w_cand};

  // bypass result is captured on request and held otherwise
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_bypass_data <= '0;
      r_bypass_mask <= '0;
    end else if (bypass_v_i) begin
      r_bypass_data <= w_bp_data;
      r_bypass_mask <= w_bp_mask;
    end
  end

endmodule

// File: tb/tb_bsg_cache_sbuf_deep.sv
// tb/tb_bsg_cache_sbuf_deep.sv - self-checking bench for bsg_cache_sbuf_deep
module tb_bsg_cache_sbuf_deep;

  localparam int EW = 39 + 64 + 8 + 3;

  typedef struct packed {
    logic [38:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
    logic [2:0]  way;
  } ent_t;

  typedef struct {
    logic        v;
    logic        yumi;
    logic [63:0] data;
    int          cnt;
    logic        full;
    logic [63:0] head;
  } row_t;

  logic clk = 1'b0;
  logic rst;

  ent_t        a_ein;
  logic        a_v, a_yumi, a_ready, a_vo, a_empty, a_full, a_bv;
  logic [EW-1:0] a_eout;
  logic [2:0]  a_cnt;
  logic [38:0] a_baddr;
  logic [63:0] a_bdata;
  logic [7:0]  a_bmask;

  ent_t        b_ein;
  logic        b_v, b_yumi, b_ready, b_vo, b_empty, b_full, b_bv;
  logic [EW-1:0] b_eout;
  logic [1:0]  b_cnt;
  logic [38:0] b_baddr;
  logic [63:0] b_bdata;
  logic [7:0]  b_bmask;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  bsg_cache_sbuf_deep #(.els_p(4)) u4 (
    .clk_i(clk), .reset_i(rst), .sbuf_entry_i(a_ein), .v_i(a_v), .ready_o(a_ready),
    .sbuf_entry_o(a_eout), .v_o(a_vo), .yumi_i(a_yumi), .empty_o(a_empty), .full_o(a_full),
    .count_o(a_cnt), .bypass_addr_i(a_baddr), .bypass_v_i(a_bv),
    .bypass_data_o(a_bdata), .bypass_mask_o(a_bmask)
  );

  bsg_cache_sbuf_deep #(.els_p(3)) u3 (
    .clk_i(clk), .reset_i(rst), .sbuf_entry_i(b_ein), .v_i(b_v), .ready_o(b_ready),
    .sbuf_entry_o(b_eout), .v_o(b_vo), .yumi_i(b_yumi), .empty_o(b_empty), .full_o(b_full),
    .count_o(b_cnt), .bypass_addr_i(b_baddr), .bypass_v_i(b_bv),
    .bypass_data_o(b_bdata), .bypass_mask_o(b_bmask)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ent_t mk(input logic [38:0] addr, input logic [63:0] data, input logic [7:0] mask);
    ent_t e;
    e.addr = addr;
    e.data = data;
    e.mask = mask;
    e.way  = 3'(addr[5:3]);
    return e;
  endfunction

  // reference bypass: every live store oldest-first, later bytes replace earlier ones
  function automatic void ref_bypass(input ent_t q[$], input ent_t inc, input logic inc_v,
                                     input logic [38:0] addr,
                                     output logic [63:0] d, output logic [7:0] m);
    ent_t all[$];
    all = q;
    if (inc_v) all.push_back(inc);
    d = '0;
    m = '0;
    foreach (all[k]) begin
      if ((all[k].addr >> 3) == (addr >> 3)) begin
        for (int b = 0; b < 8; b++) begin
          if (all[k].mask[b]) begin
            m[b] = 1'b1;
            d[8*b +: 8] = all[k].data[8*b +: 8];
          end
        end
      end
    end
  endfunction

  row_t        tbl[8];
  logic [63:0] dq[$];
  ent_t        mq[$];
  logic [38:0] base[3];

  initial begin
    rst = 1'b1;
    a_ein = '0; a_v = 0; a_yumi = 0; a_baddr = '0; a_bv = 0;
    b_ein = '0; b_v = 0; b_yumi = 0; b_baddr = '0; b_bv = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_count", 128'(a_cnt), 128'(0));
    chk("rst_empty", 128'(a_empty), 128'(1));
    chk("rst_full", 128'(a_full), 128'(0));
    chk("rst_ready", 128'(a_ready), 128'(1));
    chk("rst_bmask", 128'(a_bmask), 128'(0));
    chk("rst_vo", 128'(a_vo), 128'(0));

    // pass-through enqueue+dequeue on empty buffer
    a_ein = mk(39'h40, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    a_v = 1; a_yumi = 1;
    #1;
    chk("pt_entry", 128'(a_eout), 128'(a_ein));
    chk("pt_vo", 128'(a_vo), 128'(1));
    tick();
    a_v = 0; a_yumi = 0;
    #1;
    chk("pt_count", 128'(a_cnt), 128'(0));
    chk("pt_empty", 128'(a_empty), 128'(1));

    // fill to full then drain, table-driven
    tbl[0] = '{1, 0, 64'hA0, 1, 0, 64'hA0};
    tbl[1] = '{1, 0, 64'hA1, 2, 0, 64'hA0};
    tbl[2] = '{1, 0, 64'hA2, 3, 0, 64'hA0};
    tbl[3] = '{1, 0, 64'hA3, 4, 1, 64'hA0};
    tbl[4] = '{0, 1, 64'h00, 3, 0, 64'hA1};
    tbl[5] = '{0, 1, 64'h00, 2, 0, 64'hA2};
    tbl[6] = '{0, 1, 64'h00, 1, 0, 64'hA3};
    tbl[7] = '{0, 1, 64'h00, 0, 0, 64'h00};
    for (int i = 0; i < 8; i++) begin
      a_ein = mk(39'h1000 + 39'(i * 8), tbl[i].data, 8'hFF);
      a_v = tbl[i].v; a_yumi = tbl[i].yumi;
      tick();
      a_v = 0; a_yumi = 0;
      #1;
      chk($sformatf("tbl%0d_count", i), 128'(a_cnt), 128'(tbl[i].cnt));
      chk($sformatf("tbl%0d_full", i), 128'(a_full), 128'(tbl[i].full));
      chk($sformatf("tbl%0d_ready", i), 128'(a_ready), 128'(!tbl[i].full));
      if (tbl[i].cnt > 0) chk($sformatf("tbl%0d_head", i), 128'(a_eout[74:11]), 128'(tbl[i].head));
      else chk($sformatf("tbl%0d_vo", i), 128'(a_vo), 128'(0));
    end

    // two stores to one word, bypass from a different byte of that word
    a_ein = mk(39'h100, 64'h1111_1111_1111_1111, 8'h0F); a_v = 1;
    tick();
    a_ein = mk(39'h100, 64'h2222_2222_2222_2222, 8'h03);
    tick();
    a_v = 0; a_baddr = 39'h104; a_bv = 1;
    tick();
    a_bv = 0;
    #1;
    chk("merge_mask", 128'(a_bmask), 128'(8'h0F));
    chk("merge_data", 128'(a_bdata), 128'(64'h0000_0000_1111_2222));
    a_baddr = 39'h0;
    tick();
    chk("merge_hold", 128'(a_bmask), 128'(8'h0F));
    a_yumi = 1; tick(); tick(); a_yumi = 0;
    #1;
    chk("merge_drained", 128'(a_cnt), 128'(0));

    // incoming store is youngest
    a_ein = mk(39'h200, 64'h0102_0304_0506_0708, 8'hFF); a_v = 1;
    tick();
    a_ein = mk(39'h205, 64'hAB00_0000_0000_0000, 8'h80);
    a_baddr = 39'h200; a_bv = 1;
    tick();
    a_v = 0; a_bv = 0;
    #1;
    chk("inc_mask", 128'(a_bmask), 128'(8'hFF));
    chk("inc_data", 128'(a_bdata), 128'(64'hAB02_0304_0506_0708));
    chk("inc_count", 128'(a_cnt), 128'(2));
    a_yumi = 1; tick(); tick(); a_yumi = 0;

    // pointer wrap at depth 3
    dq.delete();
    for (int k = 0; k < 2; k++) begin
      b_ein = mk(39'h800, 64'h5500 + 64'(k), 8'hFF); b_v = 1;
      dq.push_back(b_ein.data);
      tick();
    end
    for (int k = 2; k < 12; k++) begin
      b_ein = mk(39'h800, 64'h5500 + 64'(k), 8'hFF); b_v = 1; b_yumi = 1;
      #1;
      chk($sformatf("wrap%0d_head", k), 128'(b_eout[74:11]), 128'(dq[0]));
      tick();
      void'(dq.pop_front());
      dq.push_back(b_ein.data);
    end
    b_v = 0; b_yumi = 0;
    #1;
    chk("wrap_count", 128'(b_cnt), 128'(2));
    b_ein = mk(39'h800, 64'h5500 + 64'd12, 8'hFF); b_v = 1;
    dq.push_back(b_ein.data);
    tick();
    b_ein = mk(39'h800, 64'h9999, 8'hFF); b_v = 1; b_yumi = 1;
    #1;
    chk("full_ready", 128'(b_ready), 128'(0));
    tick();
    void'(dq.pop_front());
    b_v = 0; b_yumi = 0;
    #1;
    chk("full_count", 128'(b_cnt), 128'(2));
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("tail%0d_head", k), 128'(b_eout[74:11]), 128'(dq[k]));
      b_yumi = 1; tick(); b_yumi = 0; #1;
    end
    chk("tail_empty", 128'(b_empty), 128'(1));

    // reset while full with a captured bypass
    for (int k = 0; k < 3; k++) begin
      b_ein = mk(39'h300, 64'h7700 + 64'(k), 8'hFF); b_v = 1;
      tick();
    end
    b_v = 0; b_baddr = 39'h300; b_bv = 1;
    tick();
    b_bv = 0;
    #1;
    chk("pre_rst_mask", 128'(b_bmask), 128'(8'hFF));
    chk("pre_rst_count", 128'(b_cnt), 128'(3));
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("post_rst_count", 128'(b_cnt), 128'(0));
    chk("post_rst_empty", 128'(b_empty), 128'(1));
    chk("post_rst_full", 128'(b_full), 128'(0));
    chk("post_rst_ready", 128'(b_ready), 128'(1));
    chk("post_rst_mask", 128'(b_bmask), 128'(0));
    chk("post_rst_data", 128'(b_bdata), 128'(0));

    // randomized traffic against queue model
    begin
      logic [63:0] m_bd, m_bm_d;
      logic [7:0]  m_bm, m_tmp;
      logic        exp_vo;
      ent_t        e;
      base[0] = 39'h100; base[1] = 39'h108; base[2] = 39'h3F8;
      mq.delete();
      m_bd = '0; m_bm = '0;
      for (int c = 0; c < 400; c++) begin
        e = mk(base[$urandom % 3] + 39'($urandom % 8), {$urandom, $urandom}, 8'($urandom));
        a_ein = e;
        a_v = (mq.size() < 4) ? ($urandom % 5 < 3) : 1'b0;
        exp_vo = (mq.size() > 0) || a_v;
        a_yumi = exp_vo ? ($urandom % 3 == 0) : 1'b0;
        a_bv = 1'($urandom % 2);
        a_baddr = base[$urandom % 3] + 39'($urandom % 8);
        #1;
        chk("rnd_head", 128'(a_eout), 128'((mq.size() > 0) ? mq[0] : e));
        chk("rnd_vo", 128'(a_vo), 128'(exp_vo));
        chk("rnd_count", 128'(a_cnt), 128'(mq.size()));
        chk("rnd_full", 128'(a_full), 128'(mq.size() == 4));
        chk("rnd_ready", 128'(a_ready), 128'(mq.size() != 4));
        if (a_bv) begin
          ref_bypass(mq, e, a_v, a_baddr, m_bm_d, m_tmp);
          m_bd = m_bm_d;
          m_bm = m_tmp;
        end
        tick();
        if (!(a_v && a_yumi && mq.size() == 0)) begin
          if (a_yumi) void'(mq.pop_front());
          if (a_v) mq.push_back(e);
        end
        chk("rnd_bdata", 128'(a_bdata), 128'(m_bd));
        chk("rnd_bmask", 128'(a_bmask), 128'(m_bm));
      end
      a_v = 0; a_yumi = 0; a_bv = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
